// File: rtl/sme_param.sv
`default_nettype none
// ============================================================================
// Module      : sme_param
// Description : Parametrised string-match engine. A string and then one or
//               more patterns are loaded serially (one character per cycle).
//               Candidate start positions are then scanned one per cycle and
//               the first hit is reported with its index. Patterns support a
//               '.' wildcard, '^' / '$' word anchors and optional
//               case-insensitive literal comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module sme_param #(
  parameter  int CHAR_W      = 8,
  parameter  int MAX_STR_LEN = 32,
  parameter  int MAX_PAT_LEN = 8,
  parameter  bit CASE_INSENS = 1'b0,
  localparam int IDX_W       = $clog2(MAX_STR_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  // Length counters must be able to hold the full buffer depth itself.
  localparam int LEN_W  = $clog2(MAX_STR_LEN + 1);
  localparam int PLEN_W = $clog2(MAX_PAT_LEN + 1);
  localparam int PA_W   = $clog2(MAX_PAT_LEN);
  // Wide enough for any candidate position plus any in-pattern offset.
  localparam int SUM_W  = $clog2(MAX_STR_LEN + MAX_PAT_LEN + 1);

  localparam logic [LEN_W-1:0]  c_STR_MAX   = LEN_W'(MAX_STR_LEN);
  localparam logic [PLEN_W-1:0] c_PAT_MAX   = PLEN_W'(MAX_PAT_LEN);
  localparam logic [SUM_W-1:0]  c_STR_MAX_S = SUM_W'(MAX_STR_LEN);

  localparam logic [CHAR_W-1:0] c_DOT      = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] c_CARET    = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] c_DOLLAR   = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] c_SPACE    = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] c_UP_A     = CHAR_W'(8'h41);
  localparam logic [CHAR_W-1:0] c_UP_Z     = CHAR_W'(8'h5A);
  localparam logic [CHAR_W-1:0] c_CASE_OFS = CHAR_W'(8'h20);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STR  = 3'd1,
    S_PAT  = 3'd2,
    S_SCAN = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [LEN_W-1:0]    r_str_len;
  logic [PLEN_W-1:0]   r_pat_len;
  logic [LEN_W-1:0]    r_pos;
  logic                r_valid;
  logic                r_match;
  logic [IDX_W-1:0]    r_match_index;

  logic [CHAR_W-1:0]   r_str [MAX_STR_LEN];
  logic [CHAR_W-1:0]   r_pat [MAX_PAT_LEN];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                w_str_we;
  logic [IDX_W-1:0]    w_str_wa;
  logic                w_pat_we;
  logic [PA_W-1:0]     w_pat_wa;

  logic [PA_W-1:0]     w_pat_last;
  logic                w_anchor_s;
  logic                w_anchor_e;
  logic [PLEN_W-1:0]   w_clen;
  logic [CHAR_W-1:0]   w_core [MAX_PAT_LEN];
  logic [MAX_PAT_LEN-1:0] w_ok;

  logic [SUM_W-1:0]    w_end;
  logic [IDX_W-1:0]    w_prev_idx;
  logic                w_fits;
  logic                w_start_ok;
  logic                w_end_ok;
  logic                w_hit;
  logic                w_no_cand;
  logic                w_last_cand;

  assign valid       = r_valid;
  assign match       = r_match;
  assign match_index = r_match_index;

  // Upper-case letters fold to lower case only when case-insensitive mode is
  // built in; wildcard, anchor and space detection never use folding.
  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
    if (CASE_INSENS && (c >= c_UP_A) && (c <= c_UP_Z)) begin
      return c + c_CASE_OFS;
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Buffer write control
  // --------------------------------------------------------------------------
  // Decide which buffer (if any) captures chardata this cycle; writes past
  // the buffer depth are suppressed so excess characters are dropped.
  always_comb begin
    w_str_we = 1'b0;
    w_str_wa = '0;
    w_pat_we = 1'b0;
    w_pat_wa = '0;
    case (r_state)
      S_IDLE: begin
        if (isstring) begin
          w_str_we = 1'b1;
        end else if (ispattern) begin
          w_pat_we = 1'b1;
        end
      end
      S_STR: begin
        if (isstring) begin
          w_str_we = (r_str_len < c_STR_MAX);
          w_str_wa = r_str_len[IDX_W-1:0];
        end else if (ispattern) begin
          w_pat_we = 1'b1;
        end
      end
      S_PAT: begin
        if (ispattern) begin
          w_pat_we = (r_pat_len < c_PAT_MAX);
          w_pat_wa = r_pat_len[PA_W-1:0];
        end
      end
      default: begin
        w_str_we = 1'b0;
        w_pat_we = 1'b0;
      end
    endcase
  end

  // Character storage; contents are only meaningful up to the length
  // counters, so these arrays carry no reset.
  always_ff @(posedge clk) begin
    if (w_str_we) begin
      r_str[w_str_wa] <= chardata;
    end
    if (w_pat_we) begin
      r_pat[w_pat_wa] <= chardata;
    end
  end

  // --------------------------------------------------------------------------
  // Pattern decode
  // --------------------------------------------------------------------------
  assign w_pat_last = PA_W'(r_pat_len - PLEN_W'(1));
  assign w_anchor_s = (r_pat_len != '0) && (r_pat[0] == c_CARET);
  // A one-character "^" pattern cannot also be an end anchor, so the two
  // subtractions below never underflow.
  assign w_anchor_e = (r_pat_len != '0) && (r_pat[w_pat_last] == c_DOLLAR);
  assign w_clen     = r_pat_len - PLEN_W'(w_anchor_s) - PLEN_W'(w_anchor_e);

  // Core character k sits one slot further in when a start anchor is present.
  // The top slot is never inside the core when shifted, so it needs no
  // shifted source.
  generate
    for (genvar k = 0; k < MAX_PAT_LEN; k++) begin : g_core
      if (k < MAX_PAT_LEN - 1) begin : g_shift
        assign w_core[k] = w_anchor_s ? r_pat[k+1] : r_pat[k];
      end else begin : g_top
        assign w_core[k] = r_pat[k];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Candidate evaluation: all core characters compared in parallel
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < MAX_PAT_LEN; k++) begin : g_cmp
      logic [SUM_W-1:0]  w_sidx;
      logic [CHAR_W-1:0] w_schar;
      logic              w_in_core;
      assign w_sidx    = SUM_W'(r_pos) + SUM_W'(k);
      assign w_in_core = (PLEN_W'(k) < w_clen);
      assign w_schar   = (w_sidx < c_STR_MAX_S) ? r_str[w_sidx[IDX_W-1:0]] : '0;
      assign w_ok[k]   = !w_in_core
                         || (w_core[k] == c_DOT)
                         || (fold(w_core[k]) == fold(w_schar));
    end
  endgenerate

  assign w_end      = SUM_W'(r_pos) + SUM_W'(w_clen);
  assign w_prev_idx = IDX_W'(r_pos - LEN_W'(1));
  assign w_fits     = (w_end <= SUM_W'(r_str_len));

  // Start anchor: candidate begins the string or follows a space.
  assign w_start_ok = !w_anchor_s
                      || (r_pos == '0)
                      || (r_str[w_prev_idx] == c_SPACE);

  // End anchor: candidate ends the string or is followed by a space.
  assign w_end_ok   = !w_anchor_e
                      || (w_end == SUM_W'(r_str_len))
                      || ((w_end < c_STR_MAX_S) && (r_str[w_end[IDX_W-1:0]] == c_SPACE));

  assign w_hit       = w_fits && (&w_ok) && w_start_ok && w_end_ok;
  assign w_no_cand   = (SUM_W'(w_clen) > SUM_W'(r_str_len));
  assign w_last_cand = (w_end == SUM_W'(r_str_len));

  // --------------------------------------------------------------------------
  // Control FSM with registered result outputs
  // --------------------------------------------------------------------------
  // Load/scan sequencing; valid is raised on entry to OUT and dropped after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_str_len     <= '0;
      r_pat_len     <= '0;
      r_pos         <= '0;
      r_valid       <= 1'b0;
      r_match       <= 1'b0;
      r_match_index <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (isstring) begin
            r_state   <= S_STR;
            r_str_len <= LEN_W'(1);
          end else if (ispattern) begin
            // Reuse whatever string is already loaded.
            r_state   <= S_PAT;
            r_pat_len <= PLEN_W'(1);
          end
        end

        S_STR: begin
          if (isstring) begin
            if (r_str_len < c_STR_MAX) begin
              r_str_len <= r_str_len + LEN_W'(1);
            end
          end else if (ispattern) begin
            r_state   <= S_PAT;
            r_pat_len <= PLEN_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_PAT: begin
          if (ispattern) begin
            if (r_pat_len < c_PAT_MAX) begin
              r_pat_len <= r_pat_len + PLEN_W'(1);
            end
          end else begin
            r_state <= S_SCAN;
            r_pos   <= '0;
          end
        end

        S_SCAN: begin
          if (w_no_cand) begin
            // Core longer than the string: nothing to try.
            r_state       <= S_OUT;
            r_valid       <= 1'b1;
            r_match       <= 1'b0;
            r_match_index <= '0;
          end else if (w_hit) begin
            r_state       <= S_OUT;
            r_valid       <= 1'b1;
            r_match       <= 1'b1;
            r_match_index <= r_pos[IDX_W-1:0];
          end else if (w_last_cand) begin
            r_state       <= S_OUT;
            r_valid       <= 1'b1;
            r_match       <= 1'b0;
            r_match_index <= '0;
          end else begin
            r_pos <= r_pos + LEN_W'(1);
          end
        end

        S_OUT: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sme_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sme_param
// Description : Directed bench for sme_param. A case-sensitive and a
//               case-insensitive instance share one stimulus stream; each
//               result is checked for match, index, latency and pulse count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;

  logic       valid_cs, match_cs;
  logic [4:0] idx_cs;
  logic       valid_ci, match_ci;
  logic [4:0] idx_ci;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sme_param #(
    .CHAR_W      (8),
    .MAX_STR_LEN (32),
    .MAX_PAT_LEN (8),
    .CASE_INSENS (1'b0)
  ) u_dut_cs (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid_cs),
    .match       (match_cs),
    .match_index (idx_cs)
  );

  sme_param #(
    .CHAR_W      (8),
    .MAX_STR_LEN (32),
    .MAX_PAT_LEN (8),
    .CASE_INSENS (1'b1)
  ) u_dut_ci (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid_ci),
    .match       (match_ci),
    .match_index (idx_ci)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == 0) check("idle_no_valid_str", {30'd0, valid_cs, valid_ci}, 32'd0);
      isstring  = 1'b1;
      ispattern = 1'b0;
      chardata  = s[i];
    end
  endtask

  // Ends on the negedge where ispattern drops; latency counts from there.
  task automatic send_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      if (i == 0) check("idle_no_valid_pat", {30'd0, valid_cs, valid_ci}, 32'd0);
      isstring  = 1'b0;
      ispattern = 1'b1;
      chardata  = p[i];
    end
    @(negedge clk);
    ispattern = 1'b0;
    chardata  = 8'h00;
  endtask

  task automatic wait_result(input string tag,
                             input int em_cs, input int ei_cs, input int el_cs,
                             input int em_ci, input int ei_ci, input int el_ci);
    int         lat_cs = -1;
    int         lat_ci = -1;
    int         nv_cs  = 0;
    int         nv_ci  = 0;
    logic       m_cs = 1'bx;
    logic       m_ci = 1'bx;
    logic [4:0] i_cs = 'x;
    logic [4:0] i_ci = 'x;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (valid_cs === 1'b1) begin
        nv_cs++;
        if (lat_cs < 0) begin
          lat_cs = c; m_cs = match_cs; i_cs = idx_cs;
        end
      end
      if (valid_ci === 1'b1) begin
        nv_ci++;
        if (lat_ci < 0) begin
          lat_ci = c; m_ci = match_ci; i_ci = idx_ci;
        end
      end
      if (lat_cs >= 0 && lat_ci >= 0) break;
    end
    check({tag, " cs_latency"}, lat_cs, el_cs);
    check({tag, " cs_match"},   {31'd0, m_cs}, em_cs);
    check({tag, " cs_index"},   {27'd0, i_cs}, ei_cs);
    check({tag, " cs_pulses"},  nv_cs, 1);
    check({tag, " ci_latency"}, lat_ci, el_ci);
    check({tag, " ci_match"},   {31'd0, m_ci}, em_ci);
    check({tag, " ci_index"},   {27'd0, i_ci}, ei_ci);
    check({tag, " ci_pulses"},  nv_ci, 1);
  endtask

  initial begin
    int nv;
    reset     = 1'b0;
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_cs_outputs", {25'd0, valid_cs, match_cs, idx_cs}, 32'd0);
    check("reset_ci_outputs", {25'd0, valid_ci, match_ci, idx_ci}, 32'd0);
    reset = 1'b1;

    // Basic literal match
    send_str("hello world");
    send_pat("wor");
    wait_result("t1_wor", 1, 6, 8, 1, 6, 8);

    // Anchors, back-to-back patterns on the same string
    send_pat("^wo"); wait_result("t2_caret_wo", 1, 6, 8, 1, 6, 8);
    send_pat("^el"); wait_result("t2_caret_el", 0, 0, 11, 0, 0, 11);
    send_pat("lo$"); wait_result("t2_lo_dollar", 1, 3, 5, 1, 3, 5);
    send_pat("d$");  wait_result("t2_d_dollar", 1, 10, 12, 1, 10, 12);

    // Wildcard and empty core
    send_pat("w.r"); wait_result("t3_w_dot_r", 1, 6, 8, 1, 6, 8);
    send_pat("x.."); wait_result("t3_x_dots", 0, 0, 10, 0, 0, 10);
    send_pat("^$");  wait_result("t3_empty_core", 0, 0, 13, 0, 0, 13);

    // Case folding differs between the two instances
    send_pat("WOR"); wait_result("t4_upper_wor", 0, 0, 10, 1, 6, 8);

    // Saturation: 40-char string keeps 32, 10-char pattern keeps 8
    send_str("0123456789:;<=>?@ABCDEFGHIJKLMNOPQRSTUVW");
    send_pat("NO");         wait_result("t5_chars_30_31", 1, 30, 32, 1, 30, 32);
    send_pat("PQ");         wait_result("t5_chars_32_33", 0, 0, 32, 0, 0, 32);
    send_pat("3456789:zz"); wait_result("t5_pat_trunc", 1, 3, 5, 1, 3, 5);

    // Reset in the middle of a scan
    send_str("hello world");
    send_pat("d$");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_cs_outputs", {25'd0, valid_cs, match_cs, idx_cs}, 32'd0);
    check("t6_rst_ci_outputs", {25'd0, valid_ci, match_ci, idx_ci}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nv = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (valid_cs === 1'b1 || valid_ci === 1'b1) nv++;
    end
    check("t6_no_valid_after_reset", nv, 0);
    send_str("hello world");
    send_pat("d$");
    wait_result("t6_reload", 1, 10, 12, 1, 10, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
